// File: rtl/i2c_target_responder_pkg.sv
// -----------------------------------------------------------------------------
// i2c_target_responder_pkg
// Shared types and constants for the I2C target responder.
//   e_target_states : target engine FSM states
//   I2C_NACK_BYTE   : byte sent when the fabric has no read data ready
// -----------------------------------------------------------------------------
package i2c_target_responder_pkg;

    typedef enum logic unsigned [2:0] {
        T_IDLE,
        T_ADDR,
        T_ADDR_ACK,
        T_WR_DATA,
        T_WR_ACK,
        T_RD_DATA,
        T_RD_ACK
    } e_target_states;

    localparam logic [7:0] I2C_NACK_BYTE = 8'hFF;

endpackage

// File: rtl/i2c_pin_sync.sv
// -----------------------------------------------------------------------------
// i2c_pin_sync
// Synchronises the asynchronous SCL/SDA pins and derives bus events.
// Parameters:
//   SYNC_STAGES : synchroniser depth (>= 2)
// Ports:
//   clk, rst_n         : system clock, synchronous active-low reset
//   scl_i, sda_i       : raw pin levels
//   scl, sda           : synchronised levels
//   scl_rise, scl_fall : 1-cycle pulses on SCL edges
//   start_det          : 1-cycle pulse, SDA fell while SCL high
//   stop_det           : 1-cycle pulse, SDA rose while SCL high
// -----------------------------------------------------------------------------
module i2c_pin_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;

    // Reset to the idle-bus level so leaving reset never fakes a START.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl;
            sda_prev_q <= sda;
        end
    end

    assign scl      = scl_sync_q[SYNC_STAGES-1];
    assign sda      = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise = scl & ~scl_prev_q;
    assign scl_fall = ~scl & scl_prev_q;

    // SCL must be high on both samples so an SDA change at an SCL edge is data.
    assign start_det = scl & scl_prev_q & sda_prev_q & ~sda;
    assign stop_det  = scl & scl_prev_q & ~sda_prev_q & sda;

endmodule

// File: rtl/i2c_target_responder.sv
// -----------------------------------------------------------------------------
// i2c_target_responder
// I2C target engine: address match/ACK, write bytes to the fabric, read bytes
// from the fabric onto SDA.
// Optional feature macro: I2C_CLK_STRETCH_EN (hold SCL low while tx data is
// not ready instead of sending I2C_NACK_BYTE).
// Parameters:
//   TARGET_ADDR : own 7-bit address
//   SYNC_STAGES : pin synchroniser depth
// Ports:
//   clk, rst_n          : system clock, synchronous active-low reset
//   scl_i, sda_i        : pin levels (async)
//   sda_oe, scl_oe      : 1 = pull the line low
//   rx_data, rx_valid   : received write byte and its update pulse
//   tx_req              : pulse, next read byte is sampled this cycle
//   tx_data, tx_valid   : read byte from the fabric
//   tx_underrun         : pulse, no tx data at tx_req; 8'hFF sent
//   busy                : addressed and active
// -----------------------------------------------------------------------------
module i2c_target_responder
    import i2c_target_responder_pkg::*;
#(
    parameter logic [6:0]  TARGET_ADDR = 7'h50,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic       scl_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_req,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_underrun,
    output logic       busy
);

    logic unused_scl_lvl;
    logic sda, scl_rise, scl_fall, start_det, stop_det;

    i2c_pin_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_pin_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .scl       (unused_scl_lvl),
        .sda       (sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    e_target_states state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rw_q, rw_d;
    logic       sda_oe_q, sda_oe_d;
    logic       scl_oe_q, scl_oe_d;
    logic       busy_q, busy_d;
    logic       rx_valid_q, rx_valid_d;
    logic       stretch_q, stretch_d;
    logic       load;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= T_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            rx_data_q  <= '0;
            rw_q       <= 1'b0;
            sda_oe_q   <= 1'b0;
            scl_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            stretch_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            rw_q       <= rw_d;
            sda_oe_q   <= sda_oe_d;
            scl_oe_q   <= scl_oe_d;
            busy_q     <= busy_d;
            rx_valid_q <= rx_valid_d;
            stretch_q  <= stretch_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rw_d        = rw_q;
        sda_oe_d    = sda_oe_q;
        scl_oe_d    = stretch_q;   // keeps SCL held through the tx_valid cycle
        busy_d      = busy_q;
        rx_valid_d  = 1'b0;
        stretch_d   = stretch_q;
        tx_req      = 1'b0;
        tx_underrun = 1'b0;
        load        = 1'b0;

        if (stop_det) begin
            state_d   = T_IDLE;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            scl_oe_d  = 1'b0;
            busy_d    = 1'b0;
            stretch_d = 1'b0;
        end else if (start_det) begin
            // busy is left alone: a repeated START to ourselves keeps the bus
            // owned; the address phase re-evaluates it.
            state_d   = T_ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            scl_oe_d  = 1'b0;
            stretch_d = 1'b0;
        end else if (stretch_q) begin
            if (tx_valid) begin
                shift_d   = tx_data;
                sda_oe_d  = ~tx_data[7];
                stretch_d = 1'b0;
            end
        end else begin
            case (state_q)
                T_ADDR: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda};
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d = '0;
                            rw_d      = sda;
                            if (shift_d[7:1] == TARGET_ADDR) begin
                                state_d = T_ADDR_ACK;
                                busy_d  = 1'b1;
                            end else begin
                                state_d = T_IDLE;
                                busy_d  = 1'b0;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                // sda_oe doubles as the "ACK already driven" marker.
                T_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else if (rw_q) begin
                            load = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = T_WR_DATA;
                        end
                    end
                end
                T_WR_DATA: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda};
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d  = '0;
                            rx_data_d  = shift_d;
                            rx_valid_d = 1'b1;
                            state_d    = T_WR_ACK;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                T_WR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = T_WR_DATA;
                        end
                    end
                end
                T_RD_DATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d = '0;
                            sda_oe_d  = 1'b0;
                            state_d   = T_RD_ACK;
                        end else begin
                            shift_d   = {shift_q[6:0], 1'b0};
                            sda_oe_d  = ~shift_d[7];
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                T_RD_ACK: begin
                    // Any fall here follows an ACKed 9th rise; NACK leaves at the rise.
                    if (scl_rise && sda) begin
                        state_d = T_IDLE;
                    end else if (scl_fall) begin
                        load = 1'b1;
                    end
                end
                default: ;
            endcase

            if (load) begin
                state_d   = T_RD_DATA;
                bit_cnt_d = '0;
                tx_req    = 1'b1;
`ifdef I2C_CLK_STRETCH_EN
                if (tx_valid) begin
                    shift_d  = tx_data;
                    sda_oe_d = ~tx_data[7];
                end else begin
                    sda_oe_d  = 1'b0;
                    scl_oe_d  = 1'b1;
                    stretch_d = 1'b1;
                end
`else
                if (tx_valid) begin
                    shift_d  = tx_data;
                    sda_oe_d = ~tx_data[7];
                end else begin
                    shift_d     = I2C_NACK_BYTE;
                    sda_oe_d    = 1'b0;
                    tx_underrun = 1'b1;
                end
`endif
            end
        end
    end

    assign sda_oe   = sda_oe_q;
    assign scl_oe   = scl_oe_q;   // never set unless I2C_CLK_STRETCH_EN is defined
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;

endmodule
